// File: rtl/probe_cond_pkg.sv
// rtl/probe_cond_pkg.sv - probe mode encoding shared with bpReg, plus the exponent-to-count helper
package probe_cond_pkg;

    typedef enum logic [1:0] {
        PROBE_MODE_LEVEL = 2'd0,
        PROBE_MODE_RISE  = 2'd1,
        PROBE_MODE_FALL  = 2'd2,
        PROBE_MODE_ANY   = 2'd3
    } probeMode_t;

    // 2**e - 1; callers truncate, so exponents at or above the counter width saturate to all ones
    function automatic logic [31:0] expMask(input logic [31:0] e);
        return (32'd1 << e) - 32'd1;
    endfunction

endpackage

// File: rtl/probe_cond_if.sv
// rtl/probe_cond_if.sv - probe pins, per-channel configuration and conditioned x/y streams
interface probe_cond_if
    import probe_cond_pkg::*;
#(
    parameter int N_PROBE          = 8,
    parameter int MAX_DEBOUNCE_EXP = 8,
    parameter int MAX_STRETCH_EXP  = 8
);
    localparam int SEL_W = $clog2(N_PROBE);
    localparam int DEB_W = $clog2(MAX_DEBOUNCE_EXP + 1);
    localparam int STR_W = $clog2(MAX_STRETCH_EXP + 1);

    logic [N_PROBE-1:0] i_probes;
    logic [SEL_W-1:0]   i_selX;
    logic [SEL_W-1:0]   i_selY;
    logic               i_invX;
    logic               i_invY;
    probeMode_t         i_modeX;
    probeMode_t         i_modeY;
    logic [DEB_W-1:0]   i_debExpX;
    logic [DEB_W-1:0]   i_debExpY;
    logic [STR_W-1:0]   i_strExpX;
    logic [STR_W-1:0]   i_strExpY;
    logic               o_x;
    logic               o_y;

    modport master (
        output i_probes, i_selX, i_selY, i_invX, i_invY, i_modeX, i_modeY,
               i_debExpX, i_debExpY, i_strExpX, i_strExpY,
        input  o_x, o_y
    );

    modport slave (
        input  i_probes, i_selX, i_selY, i_invX, i_invY, i_modeX, i_modeY,
               i_debExpX, i_debExpY, i_strExpX, i_strExpY,
        output o_x, o_y
    );

endinterface

// File: rtl/probe_cond_chan.sv
// rtl/probe_cond_chan.sv - one conditioning channel: config copy, debounce, event extraction, stretch
module probe_cond_chan
    import probe_cond_pkg::*;
#(
    parameter int N_PROBE          = 8,
    parameter int MAX_DEBOUNCE_EXP = 8,
    parameter int MAX_STRETCH_EXP  = 8,
    localparam int SEL_W = $clog2(N_PROBE),
    localparam int DEB_W = $clog2(MAX_DEBOUNCE_EXP + 1),
    localparam int STR_W = $clog2(MAX_STRETCH_EXP + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cg,
    input  logic [N_PROBE-1:0] syncBits,
    input  logic [SEL_W-1:0]   sel,
    input  logic               inv,
    input  probeMode_t         mode,
    input  logic [DEB_W-1:0]   debExp,
    input  logic [STR_W-1:0]   strExp,
    output logic               stream
);
    logic [SEL_W-1:0]            selQ;
    logic                        invQ;
    probeMode_t                  modeQ;
    logic [DEB_W-1:0]            debQ;
    logic [STR_W-1:0]            strQ;
    logic [MAX_DEBOUNCE_EXP-1:0] dbCnt;
    logic [MAX_STRETCH_EXP-1:0]  stCnt;
    logic [MAX_DEBOUNCE_EXP-1:0] dbLimit;
    logic [MAX_STRETCH_EXP-1:0]  stLimit;
    logic                        fQ;
    logic                        prevQ;
    logic                        raw;
    logic                        cfgChange;
    logic                        evt;

    // raw follows the live select so a config change can seed the filter with the new probe
    always_comb begin
        raw = inv;
        if (int'(sel) < N_PROBE) begin
            raw = syncBits[sel] ^ inv;
        end
    end

    always_comb begin
        cfgChange = (sel != selQ) || (inv != invQ) || (mode != modeQ) ||
                    (debExp != debQ) || (strExp != strQ);
        dbLimit   = MAX_DEBOUNCE_EXP'(expMask(32'(debQ)));
        stLimit   = MAX_STRETCH_EXP'(expMask(32'(strQ)));
    end

    always_comb begin
        evt = 1'b0;
        case (modeQ)
            PROBE_MODE_LEVEL: evt = fQ;
            PROBE_MODE_RISE:  evt = fQ & ~prevQ;
            PROBE_MODE_FALL:  evt = ~fQ & prevQ;
            PROBE_MODE_ANY:   evt = fQ ^ prevQ;
            default:          evt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            selQ   <= '0;
            invQ   <= 1'b0;
            modeQ  <= PROBE_MODE_LEVEL;
            debQ   <= '0;
            strQ   <= '0;
            dbCnt  <= '0;
            stCnt  <= '0;
            fQ     <= 1'b0;
            prevQ  <= 1'b0;
            stream <= 1'b0;
        end else if (cg) begin
            if (cfgChange) begin
                // seeding both fQ and prevQ with raw suppresses a spurious edge on reconfiguration
                selQ   <= sel;
                invQ   <= inv;
                modeQ  <= mode;
                debQ   <= debExp;
                strQ   <= strExp;
                dbCnt  <= '0;
                stCnt  <= '0;
                fQ     <= raw;
                prevQ  <= raw;
                stream <= 1'b0;
            end else begin
                prevQ <= fQ;
                if (debQ == '0) begin
                    fQ <= raw;
                end else if (raw == fQ) begin
                    dbCnt <= '0;
                end else if (dbCnt == dbLimit) begin
                    fQ    <= raw;
                    dbCnt <= '0;
                end else begin
                    dbCnt <= dbCnt + MAX_DEBOUNCE_EXP'(1);
                end

                if (evt) begin
                    stCnt  <= stLimit;
                    stream <= 1'b1;
                end else if (stCnt != '0) begin
                    stCnt  <= stCnt - MAX_STRETCH_EXP'(1);
                    stream <= 1'b1;
                end else begin
                    stream <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/probe_cond.sv
// rtl/probe_cond.sv - shared probe synchroniser feeding independent X and Y conditioning channels
module probe_cond
    import probe_cond_pkg::*;
#(
    parameter int N_PROBE          = 8,
    parameter int SYNC_STAGES      = 2,
    parameter int MAX_DEBOUNCE_EXP = 8,
    parameter int MAX_STRETCH_EXP  = 8
) (
    input logic         i_clk,
    input logic         i_rst,
    input logic         i_cg,
    probe_cond_if.slave bus
);
    logic [N_PROBE-1:0] syncQ [SYNC_STAGES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                syncQ[i] <= '0;
            end
        end else if (i_cg) begin
            syncQ[0] <= bus.i_probes;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                syncQ[i] <= syncQ[i-1];
            end
        end
    end

    probe_cond_chan #(
        .N_PROBE         (N_PROBE),
        .MAX_DEBOUNCE_EXP(MAX_DEBOUNCE_EXP),
        .MAX_STRETCH_EXP (MAX_STRETCH_EXP)
    ) chanX (
        .clk     (i_clk),
        .rst     (i_rst),
        .cg      (i_cg),
        .syncBits(syncQ[SYNC_STAGES-1]),
        .sel     (bus.i_selX),
        .inv     (bus.i_invX),
        .mode    (bus.i_modeX),
        .debExp  (bus.i_debExpX),
        .strExp  (bus.i_strExpX),
        .stream  (bus.o_x)
    );

    probe_cond_chan #(
        .N_PROBE         (N_PROBE),
        .MAX_DEBOUNCE_EXP(MAX_DEBOUNCE_EXP),
        .MAX_STRETCH_EXP (MAX_STRETCH_EXP)
    ) chanY (
        .clk     (i_clk),
        .rst     (i_rst),
        .cg      (i_cg),
        .syncBits(syncQ[SYNC_STAGES-1]),
        .sel     (bus.i_selY),
        .inv     (bus.i_invY),
        .mode    (bus.i_modeY),
        .debExp  (bus.i_debExpY),
        .strExp  (bus.i_strExpY),
        .stream  (bus.o_y)
    );

endmodule

// File: tb/tb_probe_cond.sv
// tb/tb_probe_cond.sv - directed scenarios plus randomized pins against a windowed reference model
module tb_probe_cond;
    import probe_cond_pkg::*;

    localparam int BASE = 32;
    localparam int T    = 200;
    localparam int HL   = BASE + T + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cg  = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] pinHist [HL];
    logic       obsX    [HL];
    logic       obsY    [HL];
    logic       expO    [HL];

    probe_cond_if ifc ();

    probe_cond dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_cg (cg),
        .bus  (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setX(input int sel, input int inv, input int mode, input int de, input int se);
        ifc.i_selX    = 3'(sel);
        ifc.i_invX    = 1'(inv);
        ifc.i_modeX   = probeMode_t'(mode);
        ifc.i_debExpX = 4'(de);
        ifc.i_strExpX = 4'(se);
    endtask

    task automatic setY(input int sel, input int inv, input int mode, input int de, input int se);
        ifc.i_selY    = 3'(sel);
        ifc.i_invY    = 1'(inv);
        ifc.i_modeY   = probeMode_t'(mode);
        ifc.i_debExpY = 4'(de);
        ifc.i_strExpY = 4'(se);
    endtask

    // o[c] is high iff an event occurred in the previous 2**se cycles; the filter flips
    // only after 2**de consecutive cycles of disagreement with its current value
    task automatic runModel(input int sel, input int inv, input int mode, input int de, input int se);
        logic rawM [HL];
        logic fM   [HL];
        logic evM  [HL];
        logic flip;
        int   w;
        for (int c = 0; c < HL; c++) begin
            rawM[c] = ((c >= 2) ? pinHist[c-2][sel] : pinHist[0][sel]) ^ inv[0];
        end
        w      = 1 << de;
        fM[0]  = rawM[0];
        evM[0] = 1'b0;
        for (int c = 1; c < HL; c++) begin
            fM[c] = fM[c-1];
            if (c >= w) begin
                flip = 1'b1;
                for (int j = 1; j <= w; j++) begin
                    if (rawM[c-j] == fM[c-1]) flip = 1'b0;
                end
                if (flip) fM[c] = ~fM[c-1];
            end
            case (mode)
                0:       evM[c] = fM[c];
                1:       evM[c] = fM[c] & ~fM[c-1];
                2:       evM[c] = ~fM[c] & fM[c-1];
                default: evM[c] = fM[c] ^ fM[c-1];
            endcase
        end
        for (int c = 0; c < HL; c++) begin
            expO[c] = 1'b0;
            for (int j = 1; j <= (1 << se); j++) begin
                if (c - j >= 0 && evM[c-j]) expO[c] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (ifc.o_x !== 1'b0) begin bad++; $display("FAIL reset_o_x got=%b want=0", ifc.o_x); end
        total++;
        if (ifc.o_y !== 1'b0) begin bad++; $display("FAIL reset_o_y got=%b want=0", ifc.o_y); end
        rst = 1'b0;
    endtask

    task automatic test_level_latency();
        setX(3, 0, 0, 0, 0);
        ifc.i_probes = 8'h00;
        repeat (20) tick();
        ifc.i_probes[3] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (ifc.o_x !== (k >= 4)) begin
                bad++; $display("FAIL level_latency cyc=%0d got=%b want=%b", k, ifc.o_x, (k >= 4));
            end
        end
    endtask

    task automatic test_stretch();
        int hi;
        int lastHigh;
        setX(3, 0, 1, 0, 3);
        ifc.i_probes = 8'h00;
        repeat (20) tick();
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            ifc.i_probes[3] = (k < 10);
            tick();
            if (ifc.o_x) hi++;
        end
        total++;
        if (hi != 8) begin bad++; $display("FAIL stretch_single got=%0d want=8", hi); end
        repeat (20) tick();
        hi = 0;
        lastHigh = -1;
        for (int k = 0; k < 30; k++) begin
            ifc.i_probes[3] = (k < 2) || (k >= 5 && k < 15);
            tick();
            if (ifc.o_x) begin hi++; lastHigh = k + 1; end
        end
        total++;
        if (hi != 13) begin bad++; $display("FAIL stretch_retrig_len got=%0d want=13", hi); end
        total++;
        if (lastHigh != 16) begin bad++; $display("FAIL stretch_retrig_end got=%0d want=16", lastHigh); end
    endtask

    task automatic test_debounce();
        int hi;
        int first;
        setX(3, 0, 0, 2, 0);
        ifc.i_probes = 8'h00;
        repeat (20) tick();
        hi = 0;
        for (int k = 0; k < 25; k++) begin
            ifc.i_probes[3] = (k < 3);
            tick();
            if (ifc.o_x) hi++;
        end
        total++;
        if (hi != 0) begin bad++; $display("FAIL debounce_glitch got=%0d want=0", hi); end
        repeat (10) tick();
        first = -1;
        for (int k = 0; k < 20; k++) begin
            ifc.i_probes[3] = 1'b1;
            tick();
            if (ifc.o_x && first < 0) first = k + 1;
        end
        total++;
        if (first != 7) begin bad++; $display("FAIL debounce_latency got=%0d want=7", first); end
    endtask

    task automatic test_edge_modes();
        int hi;
        int rises;
        logic prev;
        for (int m = 0; m < 2; m++) begin
            setX(3, 0, (m == 0) ? 3 : 2, 0, 0);
            ifc.i_probes = 8'h00;
            repeat (20) tick();
            hi = 0;
            rises = 0;
            prev = ifc.o_x;
            for (int k = 0; k < 50; k++) begin
                if (k < 40) ifc.i_probes[3] = ((k / 4) % 2 == 1);
                tick();
                if (ifc.o_x) hi++;
                if (ifc.o_x && !prev) rises++;
                prev = ifc.o_x;
            end
            total++;
            if (hi != ((m == 0) ? 9 : 4)) begin
                bad++; $display("FAIL edge_mode%0d_high got=%0d want=%0d", m, hi, (m == 0) ? 9 : 4);
            end
            total++;
            if (rises != ((m == 0) ? 9 : 4)) begin
                bad++; $display("FAIL edge_mode%0d_pulses got=%0d want=%0d", m, rises, (m == 0) ? 9 : 4);
            end
        end
    endtask

    task automatic test_sel_change();
        int hi;
        setX(3, 0, 1, 0, 0);
        ifc.i_probes = 8'h20;
        repeat (20) tick();
        setX(5, 0, 1, 0, 0);
        hi = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (ifc.o_x) hi++;
        end
        total++;
        if (hi != 0) begin bad++; $display("FAIL sel_change_spurious got=%0d want=0", hi); end
        ifc.i_probes[5] = 1'b0;
        repeat (6) tick();
        ifc.i_probes[5] = 1'b1;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ifc.o_x) hi++;
        end
        total++;
        if (hi != 1) begin bad++; $display("FAIL sel_change_edge got=%0d want=1", hi); end
    endtask

    task automatic test_reset_mid();
        setX(3, 0, 1, 0, 3);
        ifc.i_probes = 8'h00;
        repeat (20) tick();
        ifc.i_probes[3] = 1'b1;
        repeat (6) tick();
        total++;
        if (ifc.o_x !== 1'b1) begin bad++; $display("FAIL reset_mid_pre got=%b want=1", ifc.o_x); end
        rst = 1'b1;
        tick();
        total++;
        if (ifc.o_x !== 1'b0) begin bad++; $display("FAIL reset_mid_drop got=%b want=0", ifc.o_x); end
        rst = 1'b0;
    endtask

    task automatic test_clock_gate();
        setX(3, 0, 0, 0, 0);
        ifc.i_probes = 8'h00;
        repeat (20) tick();
        cg = 1'b0;
        ifc.i_probes[3] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            total++;
            if (ifc.o_x !== (k >= 9)) begin
                bad++; $display("FAIL clock_gate cyc=%0d got=%b want=%b", k, ifc.o_x, (k >= 9));
            end
            if (k == 5) cg = 1'b1;
        end
    endtask

    task automatic test_random();
        int cx [5];
        int cy [5];
        logic [7:0] cur;
        for (int it = 0; it < 6; it++) begin
            cx[0] = $urandom % 8; cx[1] = $urandom % 2; cx[2] = $urandom % 4;
            cx[3] = $urandom % 3; cx[4] = $urandom % 4;
            cy[0] = $urandom % 8; cy[1] = $urandom % 2; cy[2] = $urandom % 4;
            cy[3] = $urandom % 3; cy[4] = $urandom % 4;
            setX(cx[0], cx[1], cx[2], cx[3], cx[4]);
            setY(cy[0], cy[1], cy[2], cy[3], cy[4]);
            cur = 8'($urandom);
            ifc.i_probes = cur;
            for (int c = 0; c < HL; c++) pinHist[c] = cur;
            repeat (40) tick();
            for (int k = 0; k < T; k++) begin
                cur = cur ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
                ifc.i_probes = cur;
                pinHist[BASE+k] = cur;
                tick();
                obsX[BASE+k+1] = ifc.o_x;
                obsY[BASE+k+1] = ifc.o_y;
            end
            for (int c = BASE + T; c < HL; c++) pinHist[c] = cur;
            runModel(cx[0], cx[1], cx[2], cx[3], cx[4]);
            for (int c = BASE + 1; c <= BASE + T; c++) begin
                total++;
                if (obsX[c] !== expO[c]) begin
                    bad++; $display("FAIL random_x it=%0d cyc=%0d got=%b want=%b", it, c - BASE, obsX[c], expO[c]);
                end
            end
            runModel(cy[0], cy[1], cy[2], cy[3], cy[4]);
            for (int c = BASE + 1; c <= BASE + T; c++) begin
                total++;
                if (obsY[c] !== expO[c]) begin
                    bad++; $display("FAIL random_y it=%0d cyc=%0d got=%b want=%b", it, c - BASE, obsY[c], expO[c]);
                end
            end
        end
    endtask

    initial begin
        ifc.i_probes = 8'h00;
        setX(0, 0, 0, 0, 0);
        setY(0, 0, 0, 0, 0);
        test_reset();
        test_level_latency();
        test_stretch();
        test_debounce();
        test_edge_modes();
        test_sel_change();
        test_reset_mid();
        test_clock_gate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
